// File: rtl/note_path_arbiter.sv
// Note path arbiter: owns the shared buzzer/LED note path and hands it between
// free-play keys, autoplay and learn mode, with a silent gap on every switch.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_FREE  | keyboard owns the note path
//  S_AUTO  | Playmode owns the note path, auto_run high
//  S_LEARN | learn engine owns the note path, learn_run high
//  S_GAP   | silent hand-over, GAP_CYCLES long, then jump to r_target
module note_path_arbiter #(
    parameter int NOTE_W     = 4,
    parameter int GAP_CYCLES = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode_sel,
    input  logic              start_pulse,
    input  logic              back_pulse,
    input  logic              auto_done,
    input  logic              free_on,
    input  logic [NOTE_W-1:0] free_note,
    input  logic              auto_on,
    input  logic [NOTE_W-1:0] auto_note,
    input  logic              learn_on,
    input  logic [NOTE_W-1:0] learn_note,
    output logic              auto_run,
    output logic              learn_run,
    output logic              out_on,
    output logic [NOTE_W-1:0] out_note,
    output logic [1:0]        owner
);

    localparam int CNT_W = $clog2(GAP_CYCLES) + 1;

    // Encoding chosen so the state register doubles as the owner code.
    localparam logic [1:0] S_FREE  = 2'b00;
    localparam logic [1:0] S_AUTO  = 2'b01;
    localparam logic [1:0] S_LEARN = 2'b10;
    localparam logic [1:0] S_GAP   = 2'b11;

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    logic [1:0]        r_state;
    logic [1:0]        r_target;
    logic [CNT_W-1:0]  r_gap_cnt;
    logic              r_on;
    logic [NOTE_W-1:0] r_note;
    logic              r_auto_run;
    logic              r_learn_run;

    logic [1:0]        w_state_nxt;
    logic [1:0]        w_target_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_src_on;
    logic [NOTE_W-1:0] w_src_note;

    // Next owner / target / gap counter; back_pulse always beats start_pulse.
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_cnt_nxt    = r_gap_cnt;
        case (r_state)
            S_FREE: begin
                if (start_pulse && !back_pulse) begin
                    if (mode_sel == 2'b01) begin
                        w_target_nxt = S_AUTO;
                        w_state_nxt  = S_GAP;
                        w_cnt_nxt    = '0;
                    end else if (mode_sel == 2'b10) begin
                        w_target_nxt = S_LEARN;
                        w_state_nxt  = S_GAP;
                        w_cnt_nxt    = '0;
                    end
                end
            end
            S_AUTO: begin
                if (back_pulse || auto_done) begin
                    w_target_nxt = S_FREE;
                    w_state_nxt  = S_GAP;
                    w_cnt_nxt    = '0;
                end
            end
            S_LEARN: begin
                if (back_pulse) begin
                    w_target_nxt = S_FREE;
                    w_state_nxt  = S_GAP;
                    w_cnt_nxt    = '0;
                end
            end
            default: begin
                // Back retargets the gap without restarting the count.
                if (back_pulse) begin
                    w_target_nxt = S_FREE;
                end
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = w_target_nxt;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end
        endcase
    end

    // Source selection keyed on the next owner so nothing leaks across a switch edge.
    always_comb begin
        w_src_on   = 1'b0;
        w_src_note = '0;
        case (w_state_nxt)
            S_FREE: begin
                w_src_on   = free_on;
                w_src_note = free_note;
            end
            S_AUTO: begin
                w_src_on   = auto_on;
                w_src_note = auto_note;
            end
            S_LEARN: begin
                w_src_on   = learn_on;
                w_src_note = learn_note;
            end
            default: begin
                w_src_on   = 1'b0;
                w_src_note = '0;
            end
        endcase
    end

    // State, counter and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_FREE;
            r_target    <= S_FREE;
            r_gap_cnt   <= '0;
            r_on        <= 1'b0;
            r_note      <= '0;
            r_auto_run  <= 1'b0;
            r_learn_run <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_target    <= w_target_nxt;
            r_gap_cnt   <= w_cnt_nxt;
            r_on        <= w_src_on;
            r_note      <= w_src_on ? w_src_note : '0;
            r_auto_run  <= (w_state_nxt == S_AUTO);
            r_learn_run <= (w_state_nxt == S_LEARN);
        end
    end

    assign owner     = r_state;
    assign out_on    = r_on;
    assign out_note  = r_note;
    assign auto_run  = r_auto_run;
    assign learn_run = r_learn_run;

endmodule
